// File: rtl/sram_port1_arbiter.sv
// Two-requester arbiter for SRAM port 1: latches the winning request, drives the SRAM
// from registers, captures read data and returns a one-cycle ack.
// Build option: SRAM_ARB_FIXED_PRIO_EN gives A fixed priority instead of round-robin.
module sram_port1_arbiter #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic                  a_ack_q, a_ack_d;
    logic                  b_ack_q, b_ack_d;
    logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
    logic                  owner_b_q, owner_b_d;
    logic                  busy_q, busy_d;
    logic                  grant_b_c;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    // A always wins contention; B only gets the port when A is silent.
    assign grant_b_c = b_req && !a_req;
`else
    logic last_b_q, last_b_d;

    // Under contention the requester that was not served last wins.
    assign grant_b_c = b_req && (!a_req || !last_b_q);
`endif

    always_comb begin
        state_d     = state_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        owner_b_d   = owner_b_q;
`ifndef SRAM_ARB_FIXED_PRIO_EN
        last_b_d    = last_b_q;
`endif
        case (state_q)
            IDLE: begin
                ram_we_d = 1'b0;
                if (a_req || b_req) begin
                    owner_b_d   = grant_b_c;
                    ram_we_d    = grant_b_c ? b_we    : a_we;
                    ram_addr_d  = grant_b_c ? b_addr  : a_addr;
                    ram_wdata_d = grant_b_c ? b_wdata : a_wdata;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                // Read data is captured even for writes (pre-write contents).
                ram_we_d = 1'b0;
                if (owner_b_q) begin
                    b_rdata_d = ram_rdata;
                    b_ack_d   = 1'b1;
                end else begin
                    a_rdata_d = ram_rdata;
                    a_ack_d   = 1'b1;
                end
`ifndef SRAM_ARB_FIXED_PRIO_EN
                last_b_d = owner_b_q;
`endif
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                ram_we_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            owner_b_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_b_q    <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            a_ack_q     <= a_ack_d;
            b_ack_q     <= b_ack_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
            owner_b_q   <= owner_b_d;
            busy_q      <= busy_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_b_q    <= last_b_d;
`endif
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sram_port1_arbiter.sv
// Bench for sram_port1_arbiter: a 32-byte SRAM model, a transaction-level reference
// model checked every cycle, directed scenarios with literal expectations, random traffic.
module tb_sram_port1_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [4:0] a_addr = '0, b_addr = '0;
    logic [7:0] a_wdata = '0, b_wdata = '0;
    logic       a_ack, b_ack, ram_we, busy;
    logic [7:0] a_rdata, b_rdata, ram_wdata, ram_rdata;
    logic [4:0] ram_addr;

    int tests = 0;
    int fails = 0;

    sram_port1_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // SRAM port 1: asynchronous read, write on the rising edge.
    logic [7:0] sram [32];
    logic       mem_clr = 1'b1;
    assign ram_rdata = sram[ram_addr];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) sram[i] <= 8'h00;
        end else if (ram_we) begin
            sram[ram_addr] <= ram_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: one record per transaction; outputs follow from its start cycle.
    logic [7:0] mem_m [32];
    int         cyc = 0;
    int         t_start = 0;
    bit         have = 0, own_b = 0, t_we = 0, last_b = 1;
    logic [4:0] t_addr, p_addr;
    logic [7:0] t_wd, t_rd, p_wd, a_hold, b_hold;
    int         we_cnt = 0;
    bit         pick_b;

    initial begin
        for (int i = 0; i < 32; i++) mem_m[i] = 8'h00;
        t_addr = '0; p_addr = '0; t_wd = '0; t_rd = '0; p_wd = '0; a_hold = '0; b_hold = '0;
    end

    always @(negedge clk) begin
        if (ram_we) we_cnt++;
        if (!reset) begin
            chk("rst_state", {24'(0), a_ack, b_ack, ram_we, busy, 8'(ram_addr)},
                32'h0);
            chk("rst_data", {8'(0), a_rdata, b_rdata, ram_wdata}, 32'h0);
            have = 0; last_b = 1;
            p_addr = '0; p_wd = '0; a_hold = '0; b_hold = '0;
        end else begin
            chk("busy",   32'(busy),   32'(have && (cyc == t_start + 1 || cyc == t_start + 2)));
            chk("ram_we", 32'(ram_we), 32'(have && cyc == t_start + 1 && t_we));
            chk("ram_addr",  32'(ram_addr),  32'((have && cyc > t_start) ? t_addr : p_addr));
            chk("ram_wdata", 32'(ram_wdata), 32'((have && cyc > t_start) ? t_wd : p_wd));
            chk("a_ack", 32'(a_ack), 32'(have && cyc == t_start + 2 && !own_b));
            chk("b_ack", 32'(b_ack), 32'(have && cyc == t_start + 2 && own_b));
            chk("a_rdata", 32'(a_rdata),
                32'((have && !own_b && cyc >= t_start + 2) ? t_rd : a_hold));
            chk("b_rdata", 32'(b_rdata),
                32'((have && own_b && cyc >= t_start + 2) ? t_rd : b_hold));
            if ((!have || cyc >= t_start + 3) && (a_req || b_req)) begin
                if (have) begin
                    p_addr = t_addr; p_wd = t_wd;
                    if (own_b) b_hold = t_rd; else a_hold = t_rd;
                end
`ifdef SRAM_ARB_FIXED_PRIO_EN
                pick_b = b_req && !a_req;
`else
                pick_b = b_req && (!a_req || !last_b);
`endif
                last_b  = pick_b;
                own_b   = pick_b;
                t_we    = pick_b ? b_we : a_we;
                t_addr  = pick_b ? b_addr : a_addr;
                t_wd    = pick_b ? b_wdata : a_wdata;
                t_rd    = mem_m[t_addr];
                if (t_we) mem_m[t_addr] = t_wd;
                t_start = cyc;
                have    = 1;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single transaction by one side; lat counts negedges from the request cycle to ack.
    task automatic txn(input bit sb, input bit we, input logic [4:0] ad, input logic [7:0] wd,
                       output int lat, output logic [7:0] rd);
        lat = -1;
        rd  = '0;
        tick();
        if (sb) begin b_req = 1; b_we = we; b_addr = ad; b_wdata = wd; end
        else    begin a_req = 1; a_we = we; a_addr = ad; a_wdata = wd; end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (sb ? b_ack : a_ack) begin
                lat = k;
                rd  = sb ? b_rdata : a_rdata;
                break;
            end
        end
        tick();
        if (sb) b_req = 0; else a_req = 0;
    endtask

    int         lat, w0, a_at, b_at, n, acks;
    logic [7:0] rd;
    logic [3:0] ord;
    bit         sa, sb, b_seen;

    initial begin
        // Reset held for three cycles, then ten idle cycles.
        repeat (3) @(negedge clk);
        chk("reset_outputs", {28'(0), a_ack, b_ack, ram_we, busy}, 32'h0);
        tick();
        mem_clr = 1'b0;
        reset   = 1'b1;
        w0 = we_cnt;
        repeat (10) tick();
        chk("idle_no_we", 32'(we_cnt - w0), 32'd0);

        // A write then read back.
        w0 = we_cnt;
        txn(0, 1, 5'h13, 8'hA5, lat, rd);
        chk("a_wr_latency", 32'(lat), 32'd2);
        chk("a_wr_we_pulses", 32'(we_cnt - w0), 32'd1);
        chk("sram_13", 32'(sram[5'h13]), 32'hA5);
        w0 = we_cnt;
        txn(0, 0, 5'h13, 8'h00, lat, rd);
        chk("a_rd_latency", 32'(lat), 32'd2);
        chk("a_rd_data", 32'(rd), 32'hA5);
        chk("a_rd_no_we", 32'(we_cnt - w0), 32'd0);

        // Contention after reset: A first at +2, B at +5.
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        a_req = 1; a_we = 1; a_addr = 5'h00; a_wdata = 8'h11;
        b_req = 1; b_we = 1; b_addr = 5'h01; b_wdata = 8'h22;
        a_at = -1; b_at = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            sa = a_ack; sb = b_ack;
            if (sa) a_at = k;
            if (sb) b_at = k;
            tick();
            if (sa) a_req = 0;
            if (sb) b_req = 0;
        end
        chk("cont_a_at", 32'(a_at), 32'd2);
        chk("cont_b_at", 32'(b_at), 32'd5);
        chk("sram_0", 32'(sram[0]), 32'h11);
        chk("sram_1", 32'(sram[1]), 32'h22);

        // Both held for four transactions.
        a_req = 1; a_we = 0; a_addr = 5'h04;
        b_req = 1; b_we = 0; b_addr = 5'h05;
        n = 0; ord = '0; b_seen = 0;
        for (int k = 0; k < 20 && n < 4; k++) begin
            @(negedge clk);
            if (b_ack) b_seen = 1;
            if (a_ack || b_ack) begin
                ord[n] = b_ack;
                n++;
            end
            tick();
        end
        a_req = 0; b_req = 0;
        chk("order_count", 32'(n), 32'd4);
`ifdef SRAM_ARB_FIXED_PRIO_EN
        chk("order_fixed", 32'(ord), 32'b0000);
        chk("b_starved", 32'(b_seen), 32'd0);
`else
        chk("order_rr", 32'(ord), 32'b1010);
`endif
        repeat (4) tick();

        // Single-cycle request still completes exactly once.
        a_req = 1; a_we = 1; a_addr = 5'h03; a_wdata = 8'h5A;
        a_at = -1; acks = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (a_ack) begin a_at = k; acks++; end
            tick();
            a_req = 0;
        end
        chk("drop_a_at", 32'(a_at), 32'd2);
        chk("drop_acks", 32'(acks), 32'd1);
        chk("sram_3", 32'(sram[3]), 32'h5A);

        // Reset during ACCESS aborts with no ack.
        a_req = 1; a_we = 1; a_addr = 5'h07; a_wdata = 8'h77;
        @(negedge clk);
        tick();
        reset = 1'b0;
        a_req = 0;
        #1;
        chk("abort_we", 32'(ram_we), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        acks = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (a_ack) acks++;
        end
        tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (a_ack) acks++;
        end
        chk("abort_no_ack", 32'(acks), 32'd0);
        mem_m[7] = sram[7];

        // Random traffic from both sides under the handshake rules.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            sa = a_ack; sb = b_ack;
            tick();
            if (a_req) begin
                if (sa) begin
                    if ($urandom_range(0, 9) < 3) begin
                        a_we = 1'($urandom); a_addr = 5'($urandom_range(0, 7));
                        a_wdata = 8'($urandom);
                    end else a_req = 0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                a_req = 1; a_we = 1'($urandom); a_addr = 5'($urandom_range(0, 7));
                a_wdata = 8'($urandom);
            end
            if (b_req) begin
                if (sb) begin
                    if ($urandom_range(0, 9) < 3) begin
                        b_we = 1'($urandom); b_addr = 5'($urandom_range(0, 7));
                        b_wdata = 8'($urandom);
                    end else b_req = 0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                b_req = 1; b_we = 1'($urandom); b_addr = 5'($urandom_range(0, 7));
                b_wdata = 8'($urandom);
            end
        end
        a_req = 0; b_req = 0;
        repeat (6) tick();
        for (int i = 0; i < 32; i++) chk("final_mem", 32'(sram[i]), 32'(mem_m[i]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_port1_arbiter.md
Name: sram_port1_arbiter

Overview:
- Shares the single read/write port (port 1) of a 32-byte dual-port SRAM wrapper between two requesters: A (host configuration path) and B (emulator-side state updates).
- Serialises accesses, latches address, data and write-enable into registers, and drives the SRAM from those registers.
- Captures the asynchronous read data and returns it with a one-cycle ack pulse.
- Port 2 of the SRAM is untouched; it stays a free-running read port for the emulator.

Parameters:
- ADDR_WIDTH, 5, SRAM address width (32 bytes).
- DATA_WIDTH, 8, SRAM data width.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- a_req  input  1  requester A transaction request; level.
- a_we  input  1  A: 1=write, 0=read.
- a_addr  input  ADDR_WIDTH  A address.
- a_wdata  input  DATA_WIDTH  A write data.
- a_ack  output  1  one-cycle completion pulse to A.
- a_rdata  output  DATA_WIDTH  A read data; valid while a_ack=1, held until the next A completion.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as the A ports, for requester B.
- ram_we  output  1  SRAM port 1 write enable.
- ram_addr  output  ADDR_WIDTH  SRAM port 1 address.
- ram_wdata  output  DATA_WIDTH  SRAM port 1 write data.
- ram_rdata  input  DATA_WIDTH  SRAM port 1 asynchronous read data.
- busy  output  1  high when the state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous), all registered:
  - state=IDLE; ram_we=0; ram_addr=0; ram_wdata=0.
  - a_ack=b_ack=0; a_rdata=b_rdata=0.
  - Round-robin pointer `last`=B, so A wins the first contention.
- State machine IDLE -> ACCESS -> DONE -> IDLE. Each state lasts exactly one cycle.
- IDLE:
  - If any req=1, choose the winner: the sole requester, or under contention the one not equal to `last`.
  - Latch the winner's we/addr/wdata into ram_we/ram_addr/ram_wdata, record the winner, go to ACCESS.
  - If no req, stay in IDLE with ram_we=0.
- ACCESS:
  - SRAM is driven from the latched registers. A write commits at the rising edge ending this cycle.
  - ram_rdata is sampled into the winner's rdata register at the same edge. For a write, rdata is still loaded; the value equals the pre-write contents of the address.
  - ram_we clears at that edge. The winner's ack is set for the next cycle. `last` is updated to the winner.
- DONE:
  - Winner's ack=1 for this cycle only. Go to IDLE.
- Latency: req first seen high in cycle N (IDLE) -> ack high in cycle N+2. Maximum throughput is one transaction per 3 cycles.
- Handshake rules:
  - Requester holds req/we/addr/wdata stable until it sees ack.
  - Requester must drop req by the cycle after ack, or a new transaction is started.
  - Fields are sampled only in IDLE; changes after the latch are ignored.
- req deasserted during ACCESS/DONE: the transaction still completes and ack still pulses.
- Losing requester keeps req high and is served in the next IDLE. No starvation: worst-case wait is one transaction (3 cycles) plus its own 3.
- ram_addr/ram_wdata keep their last values when idle. ram_we is 1 only during ACCESS of a write.
- busy = (state != IDLE), registered.
- Reset during ACCESS: the write may or may not have committed (asynchronous abort); no ack is issued. Requesters re-issue after reset.

Optional Feature:
- Macro: SRAM_ARB_FIXED_PRIO_EN.
- Defined: round-robin is disabled and A always wins contention; `last` is not implemented. B may starve under continuous A traffic, which is acceptable for a host-config-priority build.
- Undefined: round-robin exactly as described in Behaviour.

Test Plan:
- Reset: reset=0 for 3 cycles -> all outputs 0, busy=0. Release, no reqs for 10 cycles -> ram_we never 1.
- A write then read: a_req=1, a_we=1, a_addr=5'h13, a_wdata=8'hA5. -> ram_we=1 exactly one cycle with ram_addr=13; a_ack at N+2. Then read 5'h13 -> a_rdata=8'hA5 with a_ack.
- Contention from reset: a_req and b_req both high in the same cycle, A writes 8'h11 to 0, B writes 8'h22 to 1. -> A acked first (N+2), B acked at N+5. SRAM[0]=11, SRAM[1]=22.
- Round-robin: both held high for 4 transactions -> ack order A,B,A,B. With SRAM_ARB_FIXED_PRIO_EN and A re-requesting immediately -> A,A,A,A, B never acked.
- Early drop: a_req pulsed for 1 cycle only (write 8'h5A to 3) -> transaction completes, a_ack at N+2, SRAM[3]=5A, no second transaction.
- Reset mid-ACCESS: assert reset during ACCESS -> a_ack never pulses, state IDLE, ram_we=0 immediately (asynchronous).
